// File: rtl/dma_stream_pkg.sv
// Shared defaults for the DMA stream path (FIFO burst reader and packetiser).
package dma_stream_pkg;

   localparam int DMA_DATA_WIDTH = 64;
   localparam int DMA_BURST_LEN  = 16;

   typedef enum logic {
      P_EMPTY = 1'b0,
      P_PEND  = 1'b1
   } pend_e;

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops FWFT words from the async FIFO and re-emits them as sop/eop framed bursts;
// one word is held back so eop lands on the true last beat.
module fifo_burst_reader
   import dma_stream_pkg::*;
#(
   parameter int DATA_WIDTH   = DMA_DATA_WIDTH,
   parameter int BURST_LEN    = DMA_BURST_LEN,
   parameter int IDLE_TIMEOUT = 32,
   parameter int CNT_WIDTH    = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_sop,
   output logic                  m_eop,
   input  logic                  m_ready,
   output logic                  busy
);

   localparam logic [CNT_WIDTH-1:0] BEAT_LAST = CNT_WIDTH'(BURST_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_TIMEOUT - 1);

   pend_e                 pend_q, pend_d;
   logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_sop_q, m_sop_d;
   logic                  m_eop_q, m_eop_d;
   logic [CNT_WIDTH-1:0]  beat_q, beat_d;
   logic [CNT_WIDTH-1:0]  idle_q, idle_d;

   logic pend_v;
   logic out_free;
   logic close;
   logic move;
   logic pop;

   assign pend_v   = (pend_q == P_PEND);
   assign out_free = ~m_valid_q | m_ready;
   assign close    = pend_v & ((beat_q == BEAT_LAST) | flush |
                               (fifo_empty & (idle_q == IDLE_LAST)));
   assign move     = pend_v & out_free & (close | ~fifo_empty);
   assign pop      = ~fifo_empty & (~pend_v | move);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= P_EMPTY;
         pend_data_q <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_sop_q     <= 1'b0;
         m_eop_q     <= 1'b0;
         beat_q      <= '0;
         idle_q      <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_sop_q     <= m_sop_d;
         m_eop_q     <= m_eop_d;
         beat_q      <= beat_d;
         idle_q      <= idle_d;
      end
   end

   always_comb begin
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_sop_d     = m_sop_q;
      m_eop_d     = m_eop_q;
      beat_d      = beat_q;
      idle_d      = idle_q;
      if (move) begin
         m_valid_d = 1'b1;
         m_data_d  = pend_data_q;
         m_sop_d   = (beat_q == '0);
         m_eop_d   = close;
         beat_d    = close ? '0 : beat_q + 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
      // idle time only accrues while the output could actually take the word
      if (pop) begin
         pend_d      = P_PEND;
         pend_data_d = fifo_dout;
         idle_d      = '0;
      end else if (move) begin
         pend_d = P_EMPTY;
      end else if (pend_v & fifo_empty & out_free & (idle_q != IDLE_LAST)) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_comb begin
      fifo_rd_en = ~rst & pop;
      m_valid    = m_valid_q;
      m_data     = m_data_q;
      m_sop      = m_sop_q;
      m_eop      = m_eop_q;
      busy       = pend_v | m_valid_q;
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: queue-based reference model feeds
// expected beats, an independent monitor compares accepted beats.
module tb_fifo_burst_reader;
   import dma_stream_pkg::*;

   localparam int DW = 64;
   localparam int BL = 16;
   localparam int IT = 4;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          s;
      logic          e;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic          flush = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_valid, m_sop, m_eop;
   logic          m_ready = 1'b0;
   logic          busy;

   logic [DW-1:0] fifo1_dout = '0;
   logic          fifo1_empty = 1'b1;
   logic          fifo1_rd_en;
   logic [DW-1:0] m1_data;
   logic          m1_valid, m1_sop, m1_eop;
   logic          m1_ready = 1'b1;
   logic          busy1;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .DATA_WIDTH(DW), .BURST_LEN(BL), .IDLE_TIMEOUT(IT), .CNT_WIDTH(6)
   ) dut (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data),
      .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
      .busy(busy)
   );

   fifo_burst_reader #(
      .DATA_WIDTH(DW), .BURST_LEN(1), .IDLE_TIMEOUT(IT), .CNT_WIDTH(6)
   ) dut1 (
      .clk(clk), .rst(rst), .fifo_dout(fifo1_dout), .fifo_empty(fifo1_empty),
      .fifo_rd_en(fifo1_rd_en), .flush(1'b0), .m_data(m1_data),
      .m_valid(m1_valid), .m_sop(m1_sop), .m_eop(m1_eop), .m_ready(m1_ready),
      .busy(busy1)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_w(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: FIFO and pending word as queues, burst/idle as plain ints.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] mp[$];
   beat_t         exp_q[$];
   int            m_beats = 0;
   int            m_idle = 0;
   bit            m_out = 0;
   bit            pop_pend = 0;
   int            last_pop_cyc = 0;
   int            rst_cnt = 0;

   int n_beats = 0, n_sop = 0, n_eop = 0, eop_cyc = 0;
   logic last_sop = 1'b0;

   task automatic model_reset();
      mp.delete();
      exp_q.delete();
      fq.delete();
      m_beats = 0;
      m_idle = 0;
      m_out = 0;
      pop_pend = 0;
   endtask

   task automatic push_word();
      fq.push_back({$urandom, $urandom});
   endtask

   task automatic step(input logic rdy, input logic fl);
      bit pend, free, cls, mv, pp;
      if (pop_pend) begin
         void'(fq.pop_front());
         pop_pend = 0;
      end
      m_ready = rdy;
      flush = fl;
      fifo_empty = (fq.size() == 0);
      fifo_dout = fifo_empty ? '0 : fq[0];
      #1;
      pend = (mp.size() != 0);
      free = !m_out || rdy;
      cls  = pend && (m_beats == BL - 1 || fl ||
                      (fifo_empty && m_idle == IT - 1));
      mv   = pend && free && (cls || !fifo_empty);
      pp   = !fifo_empty && (!pend || mv);
      chk_b("rd_en", fifo_rd_en, pp);
      chk_b("m_valid", m_valid, m_out);
      chk_b("busy", busy, pend || m_out);
      if (mv) begin
         exp_q.push_back('{d: mp[0], s: (m_beats == 0), e: cls});
         m_beats = cls ? 0 : m_beats + 1;
         void'(mp.pop_front());
         m_out = 1;
      end else if (rdy) begin
         m_out = 0;
      end
      if (pp) begin
         mp.push_back(fq[0]);
         m_idle = 0;
         last_pop_cyc = cyc + 1;
      end else if (pend && !mv && fifo_empty && free && m_idle < IT - 1) begin
         m_idle++;
      end
      pop_pend = fifo_rd_en && !fifo_empty;
      @(negedge clk);
   endtask

   initial begin : monitor
      bit            prev_stall;
      logic [DW-1:0] pd;
      logic          ps, pe;
      int            seen_rst;
      beat_t         e;
      prev_stall = 0;
      seen_rst = 0;
      pd = '0;
      ps = 1'b0;
      pe = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst || seen_rst != rst_cnt) begin
            prev_stall = 0;
            seen_rst = rst_cnt;
         end
         if (!rst) begin
            if (prev_stall) begin
               chk_w("stall_data", m_data, pd);
               chk_b("stall_sop", m_sop, ps);
               chk_b("stall_eop", m_eop, pe);
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h expected none", m_data);
               end else begin
                  e = exp_q.pop_front();
                  chk_w("beat_data", m_data, e.d);
                  chk_b("beat_sop", m_sop, e.s);
                  chk_b("beat_eop", m_eop, e.e);
               end
               n_beats++;
               n_sop += int'(m_sop);
               n_eop += int'(m_eop);
               last_sop = m_sop;
               if (m_eop) eop_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            ps = m_sop;
            pe = m_eop;
         end
      end
   end

   initial begin : main
      int b0, s0, e0;
      logic [DW-1:0] q1[$];
      logic [DW-1:0] ref1[$];
      bit   pattern[4];
      bit   p1;
      int   k;
      pattern = '{1'b1, 1'b0, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk_b("rst_m_valid", m_valid, 1'b0);
      chk_b("rst_m_sop", m_sop, 1'b0);
      chk_b("rst_m_eop", m_eop, 1'b0);
      chk_w("rst_m_data", m_data, '0);
      chk_b("rst_rd_en", fifo_rd_en, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      rst = 1'b0;
      model_reset();

      // three preloaded words, last one closes on the idle timeout
      repeat (3) push_word();
      b0 = n_beats; s0 = n_sop; e0 = n_eop;
      repeat (20) step(1'b1, 1'b0);
      chk_i("p1_beats", n_beats - b0, 3);
      chk_i("p1_sop", n_sop - s0, 1);
      chk_i("p1_eop", n_eop - e0, 1);
      chk_i("p1_timeout_gap", eop_cyc - last_pop_cyc, IT);
      chk_i("p1_drain", exp_q.size(), 0);

      // forty words continuous: bursts of 16,16,8
      repeat (40) push_word();
      b0 = n_beats; s0 = n_sop; e0 = n_eop;
      repeat (70) step(1'b1, 1'b0);
      chk_i("p2_beats", n_beats - b0, 40);
      chk_i("p2_sop", n_sop - s0, 3);
      chk_i("p2_eop", n_eop - e0, 3);

      // backpressure 1,0,0,1
      repeat (20) push_word();
      b0 = n_beats;
      for (int i = 0; i < 80; i++) step(pattern[i % 4], 1'b0);
      repeat (10) step(1'b1, 1'b0);
      chk_i("p3_beats", n_beats - b0, 20);
      chk_i("p3_drain", exp_q.size(), 0);

      // flush one cycle after the pop closes immediately
      push_word();
      b0 = n_beats; s0 = n_sop; e0 = n_eop;
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      chk_i("p4_beats", n_beats - b0, 1);
      chk_i("p4_sop", n_sop - s0, 1);
      chk_i("p4_eop", n_eop - e0, 1);
      chk_i("p4_flush_gap", eop_cyc - last_pop_cyc, 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1 && fq.size() < 8) push_word();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      repeat (40) step(1'b1, 1'b0);
      chk_i("p5_drain", exp_q.size(), 0);

      // async reset with both pending and output words live
      repeat (3) push_word();
      repeat (4) step(1'b0, 1'b0);
      chk_b("p6_pre_out", m_out, 1'b1);
      chk_i("p6_pre_pend", mp.size(), 1);
      #3;
      rst = 1'b1;
      rst_cnt++;
      #1;
      chk_b("p6_m_valid", m_valid, 1'b0);
      chk_b("p6_m_sop", m_sop, 1'b0);
      chk_b("p6_m_eop", m_eop, 1'b0);
      chk_w("p6_m_data", m_data, '0);
      chk_b("p6_rd_en", fifo_rd_en, 1'b0);
      chk_b("p6_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      push_word();
      b0 = n_beats;
      repeat (10) step(1'b1, 1'b0);
      chk_i("p6_beats", n_beats - b0, 1);
      chk_b("p6_sop_after", last_sop, 1'b1);
      chk_i("p6_drain", exp_q.size(), 0);

      // BURST_LEN=1 instance: every beat is sop and eop
      for (int i = 0; i < 5; i++) begin
         q1.push_back({$urandom, $urandom});
         ref1.push_back(q1[i]);
      end
      p1 = 0;
      k = 0;
      for (int i = 0; i < 30; i++) begin
         if (p1) void'(q1.pop_front());
         fifo1_empty = (q1.size() == 0);
         fifo1_dout = fifo1_empty ? '0 : q1[0];
         #1;
         if (m1_valid) begin
            if (k < 5) chk_w("bl1_data", m1_data, ref1[k]);
            chk_b("bl1_sop", m1_sop, 1'b1);
            chk_b("bl1_eop", m1_eop, 1'b1);
            k++;
         end
         p1 = fifo1_rd_en && !fifo1_empty;
         @(negedge clk);
      end
      chk_i("bl1_beats", k, 5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
